// File: rtl/serialtopara_pkg.sv
// ============================================================================
// Module      : serialtopara_pkg
// Description : Shared symbols, lane state encoding and default sizing for
//               the serial-to-parallel receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serialtopara_pkg;

    localparam int         DEFAULT_WIDTH      = 8;
    localparam int         DEFAULT_LOCK_COUNT = 4;
    localparam logic [7:0] COM_SYM            = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } lane_state_t;

endpackage

`default_nettype wire

// File: rtl/serialtopara_lane.sv
// ============================================================================
// Module      : serialtopara_lane
// Description : One receive lane: shifter, COM alignment FSM, byte output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serialtopara_lane
    import serialtopara_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] COM        = WIDTH'(COM_SYM),
    parameter int               LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
    input  logic             clk8f,
    input  logic             reset,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             stb,
    output logic             locked
);

    localparam int             BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int             CW       = $clog2(LOCK_COUNT + 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0]  COM_LAST = CW'(LOCK_COUNT - 1);
    localparam logic [CW-1:0]  COM_MAX  = CW'(LOCK_COUNT);
    localparam logic [CW-1:0]  COM_ONE  = CW'(1);

    lane_state_t        r_state;
    lane_state_t        w_state_nxt;
    logic [WIDTH-2:0]   r_sr;
    logic [BW-1:0]      r_bitcnt;
    logic [BW-1:0]      w_bitcnt_nxt;
    logic [CW-1:0]      r_comcnt;
    logic [CW-1:0]      w_comcnt_nxt;
    logic [WIDTH-1:0]   r_out;
    logic               r_valid;
    logic               r_stb;
    logic               w_load;

    logic [WIDTH-1:0]   w_nb;
    logic               w_is_com;
    logic               w_boundary;

    // The MSB of the spec's WIDTH-bit shifter is never observed, so it is not kept.
    assign w_nb       = {r_sr, sin};
    assign w_is_com   = (w_nb == COM);
    assign w_boundary = (r_bitcnt == BIT_LAST);

    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SEARCH: begin
                if (w_is_com) begin
                    w_state_nxt = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
                end
            end
            ALIGN: begin
                if (w_boundary) begin
                    if (!w_is_com) begin
                        w_state_nxt = SEARCH;
                    end else if (r_comcnt == COM_LAST) begin
                        w_state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                w_state_nxt = LOCKED;
            end
            default: begin
                w_state_nxt = SEARCH;
            end
        endcase
    end

    // A byte is presented on every locked boundary and on the edge that locks.
    always_comb begin
        w_bitcnt_nxt = (r_bitcnt == BIT_LAST) ? '0 : r_bitcnt + 1'b1;
        w_comcnt_nxt = r_comcnt;
        w_load       = 1'b0;
        case (r_state)
            SEARCH: begin
                w_bitcnt_nxt = '0;
                w_comcnt_nxt = w_is_com ? COM_ONE : '0;
                w_load       = w_is_com && (LOCK_COUNT == 1);
            end
            ALIGN: begin
                if (w_boundary) begin
                    if (w_is_com) begin
                        w_comcnt_nxt = (r_comcnt == COM_MAX) ? r_comcnt : r_comcnt + 1'b1;
                        w_load       = (r_comcnt == COM_LAST);
                    end else begin
                        w_comcnt_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                w_load = w_boundary;
            end
            default: begin
                w_bitcnt_nxt = '0;
                w_comcnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            r_sr     <= '0;
            r_bitcnt <= '0;
            r_comcnt <= '0;
            r_out    <= '0;
            r_valid  <= 1'b0;
            r_stb    <= 1'b0;
        end else begin
            r_sr     <= w_nb[WIDTH-2:0];
            r_bitcnt <= w_bitcnt_nxt;
            r_comcnt <= w_comcnt_nxt;
            r_stb    <= w_load;
            if (w_load) begin
                r_out   <= w_nb;
                r_valid <= !w_is_com;
            end
        end
    end

    assign out    = r_out;
    assign valid  = r_valid;
    assign stb    = r_stb;
    assign locked = (r_state == LOCKED);

endmodule

`default_nettype wire

// File: rtl/serialtopara.sv
// ============================================================================
// Module      : serialtopara
// Description : Dual-lane serial-to-parallel receiver with COM byte alignment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serialtopara
    import serialtopara_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] COM        = WIDTH'(COM_SYM),
    parameter int               LOCK_COUNT = DEFAULT_LOCK_COUNT
) (
    input  logic             clk8f,
    input  logic             reset,
    input  logic             in0,
    input  logic             in1,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic             valid0,
    output logic             valid1,
    output logic             stb0,
    output logic             stb1,
    output logic             active
);

    logic w_locked0;
    logic w_locked1;
    logic r_active;

    serialtopara_lane #(
        .WIDTH      (WIDTH),
        .COM        (COM),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lane0 (
        .clk8f  (clk8f),
        .reset  (reset),
        .sin    (in0),
        .out    (out0),
        .valid  (valid0),
        .stb    (stb0),
        .locked (w_locked0)
    );

    serialtopara_lane #(
        .WIDTH      (WIDTH),
        .COM        (COM),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lane1 (
        .clk8f  (clk8f),
        .reset  (reset),
        .sin    (in1),
        .out    (out1),
        .valid  (valid1),
        .stb    (stb1),
        .locked (w_locked1)
    );

    always_ff @(posedge clk8f or negedge reset) begin
        if (!reset) begin
            r_active <= 1'b0;
        end else begin
            r_active <= w_locked0 & w_locked1;
        end
    end

    assign active = r_active;

endmodule

`default_nettype wire

// File: tb/tb_serialtopara.sv
// ============================================================================
// Module      : tb_serialtopara
// Description : Directed testbench for the dual-lane serial-to-parallel receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serialtopara;

    logic       clk8f;
    logic       reset;
    logic       in0;
    logic       in1;
    logic [7:0] out0;
    logic [7:0] out1;
    logic       valid0;
    logic       valid1;
    logic       stb0;
    logic       stb1;
    logic       active;

    int checks   = 0;
    int failures = 0;
    int n_stb0;
    int n_stb1;
    logic act_b0;
    logic stb_b0;

    serialtopara u_dut (
        .clk8f  (clk8f),
        .reset  (reset),
        .in0    (in0),
        .in1    (in1),
        .out0   (out0),
        .out1   (out1),
        .valid0 (valid0),
        .valid1 (valid1),
        .stb0   (stb0),
        .stb1   (stb1),
        .active (active)
    );

    initial clk8f = 1'b0;
    always #5 clk8f = ~clk8f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bit2(input logic a, input logic b);
        in0 = a;
        in1 = b;
        @(posedge clk8f);
        #1;
    endtask

    // Sends one byte per lane MSB first, counting strobes seen after each bit.
    task automatic byte2(input logic [7:0] a, input logic [7:0] b);
        n_stb0 = 0;
        n_stb1 = 0;
        for (int i = 7; i >= 0; i--) begin
            bit2(a[i], b[i]);
            if (i == 7) begin
                act_b0 = active;
                stb_b0 = stb0 | stb1;
            end
            if (stb0) n_stb0++;
            if (stb1) n_stb1++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk8f);
        #1;
        reset = 1'b1;
    endtask

    logic [42:0] s0;
    logic [42:0] s1;
    int idx_stb0;
    int idx_stb1;
    int idx_act;

    initial begin
        reset = 1'b0;
        in0   = 1'b0;
        in1   = 1'b0;

        // Reset held with random line activity
        for (int i = 0; i < 20; i++) begin
            in0 = 1'($urandom);
            in1 = 1'($urandom);
            @(posedge clk8f);
            #1;
            chk("reset_outputs", {9'd0, out0, out1, valid0, valid1, stb0, stb1, active}, 32'd0);
        end
        reset = 1'b1;

        // Aligned lanes: 4x COM then AA, EE
        for (int k = 0; k < 3; k++) begin
            byte2(8'hBC, 8'hBC);
            chk("pre_lock_no_stb", n_stb0 + n_stb1, 0);
        end
        byte2(8'hBC, 8'hBC);
        chk("lock_stb", {stb0, stb1}, 2'b11);
        chk("lock_out", {out0, out1}, 16'hBCBC);
        chk("lock_valid", {valid0, valid1}, 2'b00);
        chk("lock_active_not_yet", active, 1'b0);
        byte2(8'hAA, 8'hAA);
        chk("active_one_later", act_b0, 1'b1);
        chk("stb_one_cycle", stb_b0, 1'b0);
        chk("aa_out", {out0, out1}, 16'hAAAA);
        chk("aa_valid", {valid0, valid1, stb0, stb1}, 4'b1111);
        byte2(8'hEE, 8'hEE);
        chk("ee_out", {out0, out1, valid0, valid1}, 18'h3BBBB);

        // Locked: EE, COM, CC gives valid 1,0,1 with one strobe per byte
        byte2(8'hEE, 8'hEE);
        chk("seq_ee", {out0, valid0, out1, valid1}, {8'hEE, 1'b1, 8'hEE, 1'b1});
        chk("seq_ee_stb", {n_stb0[7:0], n_stb1[7:0], 6'd0, stb0, stb1}, {8'd1, 8'd1, 8'd3});
        byte2(8'hBC, 8'hBC);
        chk("seq_com_idle", {out0, valid0, out1, valid1}, {8'hBC, 1'b0, 8'hBC, 1'b0});
        chk("seq_com_stb", {n_stb0[7:0], n_stb1[7:0], 6'd0, stb0, stb1}, {8'd1, 8'd1, 8'd3});
        byte2(8'hCC, 8'hCC);
        chk("seq_cc", {out0, valid0, out1, valid1}, {8'hCC, 1'b1, 8'hCC, 1'b1});

        // Lane 1 streams FF while lane 0 idles: no relock, active held
        for (int k = 0; k < 3; k++) begin
            byte2(8'hBC, 8'hFF);
            chk("ff_lane1", {out1, valid1, n_stb1[7:0]}, {8'hFF, 1'b1, 8'd1});
            chk("ff_lane0_idle", {out0, valid0, active}, {8'hBC, 1'b0, 1'b1});
        end

        // Asynchronous reset while locked, observed before the next edge
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", {9'd0, out0, out1, valid0, valid1, stb0, stb1, active}, 32'd0);
        @(posedge clk8f);
        #1;
        reset = 1'b1;

        // 3x COM, FF breaks alignment; lock on 4th COM of the second run
        for (int k = 0; k < 3; k++) begin
            byte2(8'hBC, 8'hBC);
            chk("run1_no_stb", n_stb0 + n_stb1, 0);
        end
        byte2(8'hFF, 8'hFF);
        chk("ff_no_lock", {n_stb0[7:0], n_stb1[7:0], out0, valid0}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            byte2(8'hBC, 8'hBC);
            chk("run2_no_stb", n_stb0 + n_stb1, 0);
        end
        byte2(8'hBC, 8'hBC);
        chk("run2_lock", {stb0, stb1, valid0, valid1, out0}, {4'b1100, 8'hBC});
        byte2(8'hBB, 8'hBB);
        chk("run2_bb", {out0, valid0, out1, valid1, active}, {8'hBB, 1'b1, 8'hBB, 1'b1, 1'b1});

        // Lane skew: lane 0 preceded by three junk bits
        do_reset();
        s0 = {3'b101, 32'hBCBC_BCBC, 8'hCC};
        s1 = {32'hBCBC_BCBC, 8'hCC, 3'b000};
        idx_stb0 = -1;
        idx_stb1 = -1;
        idx_act  = -1;
        for (int i = 0; i < 43; i++) begin
            bit2(s0[42-i], s1[42-i]);
            if (stb0 && idx_stb0 < 0) idx_stb0 = i;
            if (stb1 && idx_stb1 < 0) idx_stb1 = i;
            if (active && idx_act < 0) idx_act = i;
        end
        chk("skew_stb1_idx", idx_stb1, 31);
        chk("skew_stb0_idx", idx_stb0, 34);
        chk("skew_active_idx", idx_act, 35);
        chk("skew_cc", {out0, valid0, out1, valid1}, {8'hCC, 1'b1, 8'hCC, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serialtopara.md
Name: serialtopara

Overview:
- Dual-lane serial-to-parallel receiver. It is the far end of the paratoserial link.
- Each lane samples one bit per clk8f edge, MSB first, and hunts for COM (8'hBC) byte alignment.
- A lane locks after LOCK_COUNT consecutive aligned COM bytes, then delivers each received byte in parallel.
- COM bytes received after lock are idle fill: they are marked invalid and are not pushed downstream.

Parameters:
- WIDTH, 8, byte width in bits.
- COM, 8'hBC, idle/alignment symbol.
- LOCK_COUNT, 4, consecutive aligned COM bytes required for lock.

Ports:
- clk8f  input  1  bit clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- in0  input  1  lane 0 serial data.
- in1  input  1  lane 1 serial data.
- out0  output  WIDTH  lane 0 received byte.
- out1  output  WIDTH  lane 1 received byte.
- valid0  output  1  lane 0 out0 holds a data (non-COM) byte.
- valid1  output  1  lane 1 out1 holds a data (non-COM) byte.
- stb0  output  1  one-cycle pulse at each lane 0 byte boundary while locked.
- stb1  output  1  one-cycle pulse at each lane 1 byte boundary while locked.
- active  output  1  both lanes locked.

Behaviour:
- Reset (reset==0, asynchronous):
  - All outputs are 0.
  - Shift registers, bit counters and COM counters are 0.
  - Both lanes are in SEARCH.
  - Reset applied mid-operation drops lock immediately; no partial byte survives.
- Per lane, every posedge:
  - sr <= {sr[WIDTH-2:0], in}.
  - nb = {sr[WIDTH-2:0], in} is the byte completed by this edge.
- Lane FSM states: SEARCH, ALIGN, LOCKED.
- SEARCH:
  - nb is evaluated every cycle.
  - If nb==COM: bitcnt<=0, comcnt<=1, go to ALIGN. The boundary is now fixed at this bit offset.
  - If LOCK_COUNT==1, go straight to LOCKED instead.
- ALIGN:
  - bitcnt increments mod WIDTH.
  - At a boundary (bitcnt==WIDTH-1), nb==COM: comcnt++. If comcnt+1==LOCK_COUNT, go to LOCKED.
  - At a boundary, nb!=COM: go to SEARCH, comcnt<=0. The next SEARCH compare occurs on the following edge, so no re-check of the same byte.
- Lock-transition edge:
  - On the edge that enters LOCKED, stb pulses with out=COM and valid=0.
  - out is not updated in ALIGN.
- LOCKED:
  - bitcnt continues mod WIDTH.
  - At each boundary: out<=nb, valid<=(nb!=COM), stb<=1 for exactly one cycle.
  - out and valid hold between boundaries, i.e. they are stable for WIDTH cycles.
  - Latency: out changes on the same edge that samples the byte's LSB.
  - Lock persists until reset; there is no loss-of-lock detection.
- Downstream push condition: stb & valid.
- active:
  - Registered; active <= (lane0==LOCKED) & (lane1==LOCKED).
  - It rises one cycle after the later lane locks.
- Lane independence:
  - Lanes align independently, and any inter-lane bit skew is tolerated.
  - Boundaries need not coincide; stb0 and stb1 may differ in phase.
- comcnt width is clog2(LOCK_COUNT+1); it saturates and never wraps.

Decomposition:
- Shared package holds:
  - COM_SYM = 8'hBC.
  - Lane state enum {SEARCH, ALIGN, LOCKED}.
  - Default WIDTH and LOCK_COUNT.
- Sub-module serialtopara_lane contains shifter, FSM, counters, out/valid/stb. It is instantiated twice.
- The top adds only the active register.

Test Plan:
1. Reset held low for 20 cycles with random in0/in1 -> out0=out1=0, valid*=0, stb*=0, active=0. Assert reset mid-LOCKED -> same values asynchronously, before the next edge.
2. Both lanes aligned: 4x 8'hBC then 8'hAA, 8'hEE, MSB first:
   - stb pulses at the 4th COM with out=BC, valid=0.
   - active=1 one cycle later.
   - Next boundary: out=AA, valid=1. Then out=EE, valid=1.
3. Lane 0 preceded by 3 junk bits (101), lane 1 by 0 bits; same 4x BC then 8'hCC on both:
   - Each lane locks at its own offset.
   - active rises one cycle after lane 0 locks.
   - out0=out1=CC, with stb0 three cycles after stb1.
4. 3x BC, 8'hFF, then 4x BC, 8'hBB:
   - No lock after the first three COMs; FF returns the lane to SEARCH.
   - Lock occurs on the 4th COM of the second run; then out=BB, valid=1.
5. Locked link sends 8'hEE, 8'hBC, 8'hCC -> valid sequence 1, 0, 1; stb pulses every 8 cycles; out=EE, BC, CC.
6. Locked link, lane 1 only sends 8'hFF continuously:
   - active stays 1; no relock.
   - valid1=1 with out1=FF every byte.
